// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard controller: forward-select
// encodings and the load-use stall FSM states.
package hazard_pkg;
    localparam int FWD_RF    = 0;
    localparam int FWD_W     = 1;
    localparam int FWD_M     = 2;
    localparam int FWD_HIST0 = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;
endpackage

// File: rtl/fwd_sel.sv
// Forward select for one execute-stage source operand.
// Priority is M, then W, then history entry 0, 1, and so on.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int HIST_D = 1,
    parameter int HIST_N = 1,
    parameter int FW_W   = 2
) (
    input  logic [REG_AW-1:0]             i_src,
    input  logic                          i_m_we,
    input  logic [REG_AW-1:0]             i_m_rd,
    input  logic                          i_w_we,
    input  logic [REG_AW-1:0]             i_w_rd,
    input  logic [HIST_N-1:0]             i_h_we,
    input  logic [HIST_N-1:0][REG_AW-1:0] i_h_rd,
    output logic [FW_W-1:0]               o_sel
);
    logic w_nz;
    assign w_nz = (i_src != '0);

    // Walk lowest priority first so later (higher priority) matches overwrite.
    always_comb begin
        o_sel = FW_W'(FWD_RF);
        for (int k = HIST_N-1; k >= 0; k--) begin
            if (k < HIST_D && w_nz && i_h_we[k] && i_h_rd[k] == i_src)
                o_sel = FW_W'(FWD_HIST0 + k);
        end
        if (w_nz && i_w_we && i_w_rd == i_src)
            o_sel = FW_W'(FWD_W);
        if (w_nz && i_m_we && i_m_rd == i_src)
            o_sel = FW_W'(FWD_M);
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-operand forwarding selects plus a
// load-use stall FSM with branch-flush override.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_SRC       = 2,
    parameter int WB_HIST_DEPTH = 1,
    parameter int LOAD_LAT      = 1,
    parameter int REG_AW        = 5,
    parameter int FW_W          = $clog2(WB_HIST_DEPTH + 3)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      RegWriteM,
    input  logic [REG_AW-1:0]         RD_M,
    input  logic                      RegWriteW,
    input  logic [REG_AW-1:0]         RD_W,
    input  logic [NUM_SRC*REG_AW-1:0] Rs_E,
    input  logic [NUM_SRC*REG_AW-1:0] Rs_D,
    input  logic                      MemReadE,
    input  logic [REG_AW-1:0]         RD_E,
    input  logic                      PCSrcE,
    output logic [NUM_SRC*FW_W-1:0]   Forward_E,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      FlushD,
    output logic                      FlushE
);
    localparam int HIST_N = (WB_HIST_DEPTH > 0) ? WB_HIST_DEPTH : 1;
    localparam int CNT_W  = $clog2(LOAD_LAT + 1);

    logic [HIST_N-1:0]             w_h_we;
    logic [HIST_N-1:0][REG_AW-1:0] w_h_rd;

    generate
        if (WB_HIST_DEPTH > 0) begin : g_hist
            logic [HIST_N-1:0]             r_h_we;
            logic [HIST_N-1:0][REG_AW-1:0] r_h_rd;

            // Shifts unconditionally; stalls do not freeze writeback history.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_h_we <= '0;
                    r_h_rd <= '0;
                end else begin
                    for (int k = HIST_N-1; k > 0; k--) begin
                        r_h_we[k] <= r_h_we[k-1];
                        r_h_rd[k] <= r_h_rd[k-1];
                    end
                    r_h_we[0] <= RegWriteW;
                    r_h_rd[0] <= RD_W;
                end
            end
            assign w_h_we = r_h_we;
            assign w_h_rd = r_h_rd;
        end else begin : g_nohist
            assign w_h_we = '0;
            assign w_h_rd = '0;
        end
    endgenerate

    logic [NUM_SRC-1:0][FW_W-1:0] w_sel;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            fwd_sel #(
                .REG_AW (REG_AW),
                .HIST_D (WB_HIST_DEPTH),
                .HIST_N (HIST_N),
                .FW_W   (FW_W)
            ) u_fwd_sel (
                .i_src  (Rs_E[i*REG_AW +: REG_AW]),
                .i_m_we (RegWriteM),
                .i_m_rd (RD_M),
                .i_w_we (RegWriteW),
                .i_w_rd (RD_W),
                .i_h_we (w_h_we),
                .i_h_rd (w_h_rd),
                .o_sel  (w_sel[i])
            );
        end
    endgenerate

    assign Forward_E = reset ? '0 : w_sel;

    logic w_lu;
    always_comb begin
        w_lu = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (Rs_D[i*REG_AW +: REG_AW] == RD_E)
                w_lu = 1'b1;
        end
        w_lu = w_lu && MemReadE && (RD_E != '0);
    end

    hz_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        StallF      = 1'b0;
        StallD      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        if (reset) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (PCSrcE) begin
            FlushD      = 1'b1;
            FlushE      = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_lu) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_state_nxt = ST_STALL;
                            w_cnt_nxt   = CNT_W'(LOAD_LAT - 1);
                        end
                    end
                end
                ST_STALL: begin
                    // E holds a bubble here, so load-use is not re-evaluated.
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 2, number of execute-stage source operands checked for forwarding.
REQ-002 Parameter WB_HIST_DEPTH, default 1, number of post-writeback history stages tracked internally (range 0..4).
REQ-003 Parameter LOAD_LAT, default 1, stall cycles inserted on a load-use hazard (range 1..4).
REQ-004 Parameter REG_AW, default 5, register address width.
REQ-005 Derived constant FW_W = clog2(WB_HIST_DEPTH+3), forward-select width.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 RegWriteM  in  1  memory-stage instruction writes a register.
REQ-009 RD_M  in  REG_AW  memory-stage destination.
REQ-010 RegWriteW  in  1  writeback-stage instruction writes a register.
REQ-011 RD_W  in  REG_AW  writeback-stage destination.
REQ-012 Rs_E  in  NUM_SRC*REG_AW  execute-stage sources, operand i at bits [i*REG_AW +: REG_AW].
REQ-013 Rs_D  in  NUM_SRC*REG_AW  decode-stage sources, same packing.
REQ-014 MemReadE  in  1  execute-stage instruction is a load.
REQ-015 RD_E  in  REG_AW  execute-stage destination.
REQ-016 PCSrcE  in  1  taken branch/jump resolved in execute.
REQ-017 Forward_E  out  NUM_SRC*FW_W  per-operand forward select, operand i at [i*FW_W +: FW_W].
REQ-018 StallF, StallD  out  1 each  hold PC / IF-ID register.
REQ-019 FlushD, FlushE  out  1 each  bubble IF-ID / ID-EX register.

Function
REQ-020 Forward select encoding: 0 register file, 1 W stage, 2 M stage, 3+k history stage k (k=0 newest).
REQ-021 Forward select priority: M over W over history 0 over history 1, and so on; first match wins.
REQ-022 A source matches a stage only if that stage's write flag is 1, addresses are equal, and the source address is nonzero; x0 never forwards.
REQ-023 Forward_E and the hazard outputs are combinational from inputs and current state; zero-cycle latency.
REQ-024 History: a WB_HIST_DEPTH-entry shift register of {RegWriteW, RD_W}; entry 0 loads from the W inputs each cycle and entry k loads from entry k-1; it shifts every cycle, including during stalls.
REQ-025 With WB_HIST_DEPTH=0, no history state exists and encodings 3+ are never produced.
REQ-026 Load-use detect: MemReadE=1, RD_E nonzero, and RD_E equals any Rs_D operand.
REQ-027 FSM states: IDLE and STALL, with a down-counter cnt of width clog2(LOAD_LAT+1).
REQ-028 IDLE with load-use and PCSrcE=0: StallF=StallD=FlushE=1 this cycle; if LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1, otherwise stay in IDLE.
REQ-029 In STALL: StallF=StallD=FlushE=1 and cnt decrements each cycle; return to IDLE in the cycle cnt reaches 1 (total stall length = LOAD_LAT cycles).
REQ-030 In STALL, load-use detect is ignored (E holds a bubble); no re-trigger and no counter extension.
REQ-031 PCSrcE=1: FlushD=FlushE=1 and StallF=StallD=0 that cycle, and the FSM goes to IDLE; the branch overrides any load-use or STALL.
REQ-032 All stall/flush outputs are 0 in IDLE when neither condition holds.

Reset
REQ-033 When reset=1 at a clock edge: FSM to IDLE, cnt to 0, every history entry to {0,0}.
REQ-034 While reset=1: Forward_E all 0 and StallF, StallD, FlushD, FlushE all 0, regardless of other inputs.
REQ-035 Reset asserted mid-STALL aborts the stall; the first cycle after reset deasserts is in IDLE with empty history.

Structure
REQ-036 Shared package hazard_pkg holds the forward-select constants (FWD_RF, FWD_W, FWD_M, FWD_HIST0) and the FSM state enum.
REQ-037 One sub-module, fwd_sel, computes one operand's select from the M, W and history vectors and is instantiated NUM_SRC times by generate.

Verification
REQ-038 M and W both write x5, Rs_E op0=x5 -> op0 select 2 (M wins).
REQ-039 Defaults; W writes x7 at cycle t; at t+1 Rs_E op1=x7 with no M/W match -> op1 select 3.
REQ-040 RegWriteM=1, RD_M=0, Rs_E op0=0 -> op0 select 0.
REQ-041 LOAD_LAT=3; MemReadE=1, RD_E=x9, Rs_D op1=x9 -> StallF, StallD, FlushE high for exactly 3 cycles, then low.
REQ-042 LOAD_LAT=3; PCSrcE=1 in the second stall cycle -> FlushD=FlushE=1 and StallF=StallD=0 that cycle, IDLE next cycle.
REQ-043 Reset pulsed in the second cycle of a 3-cycle stall -> all outputs 0 after reset; a Rs_E match against the pre-reset W destination gives select 0.
